twiddle_rotator_pipe: RTL and testbench
=======================================

Name: twiddle_rotator_pipe

Overview:
Parametrised, pipelined complex twiddle rotator for the serial single-path FFT datapath. Complex samples arrive interleaved on one bus, real beat then imaginary beat. Each pair is multiplied by a twiddle (cos, sin) with optional conjugation for inverse FFT. The block adds valid qualification with input gaps, pair resync, configurable rounding and saturation, and a sticky overflow flag. It sits between a butterfly stage output and the next delay-feedback stage.

Parameters:
DATA_WIDTH, 16, signed width of each re/im data beat in and out
TW_WIDTH, 16, signed twiddle component width, Q1.(TW_WIDTH-1): value = tw / 2^(TW_WIDTH-1)
ROUND, 1, 0 = truncate (floor), 1 = round half up (add 2^(TW_WIDTH-2) before shift)
SAT, 1, 1 = clip to DATA_WIDTH signed range, 0 = wrap (keep low DATA_WIDTH bits)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data beat valid this cycle
in_sop  input  1  with in_valid: force this beat to be a real beat (pair resync)
in_data  input  DATA_WIDTH  interleaved re/im sample beat, signed
tw_cos  input  TW_WIDTH  twiddle real part, signed; sampled on the imaginary beat
tw_sin  input  TW_WIDTH  twiddle imag part, signed; sampled on the imaginary beat
inverse  input  1  1 = conjugate twiddle; sampled on the imaginary beat
ovf_clr  input  1  synchronous clear of ovf
out_valid  output  1  out_data valid
out_im  output  1  1 = current out beat is imaginary, 0 = real
out_data  output  DATA_WIDTH  rotated interleaved beat, signed
ovf  output  1  sticky: saturation/wrap occurred on any result
sop_err  output  1  one-cycle pulse: in_sop arrived while an imaginary beat was expected

Behaviour:
- Reset (async, rst_n=0): phase=0 (expect re), all pipeline valids 0, out_valid=0, out_im=0, out_data=0, ovf=0, sop_err=0. Reset mid-pair or mid-pipeline discards all partial and in-flight data.
- Phase: an accepted beat (in_valid=1) with phase=0 is latched as re (a); phase toggles. An accepted beat with phase=1 is im (b); that cycle also samples tw_cos (c), tw_sin (s), inverse and launches the pair. Cycles with in_valid=0 leave phase and the latched re unchanged, so gaps of any length are allowed, including between re and im.
- in_sop=1 with in_valid=1: the beat is treated as re and phase becomes 1. If phase was 1, the stale latched re is dropped and sop_err pulses the next cycle.
- Math, forward (inverse=0): RE = a*c - b*s, IM = b*c + a*s. Inverse=1: RE = a*c + b*s, IM = b*c - a*s.
- Widths: products DATA_WIDTH+TW_WIDTH bits; sum/difference DATA_WIDTH+TW_WIDTH+1 bits, full precision. Apply optional rounding offset, then arithmetic shift right by TW_WIDTH-1, giving a DATA_WIDTH+2 bit result. Reduce to DATA_WIDTH by SAT rule. Overflow means the value is outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Pipeline: launch edge E samples the im beat. E+1 registers the four products and the mode. E+2 registers rounded, reduced RE and IM plus overflow bits. Output: RE on out_data with out_valid=1, out_im=0 after edge E+3. IM with out_im=1 after edge E+4.
- Latency is fixed at 3 cycles from im acceptance to RE output, independent of gaps.
- Pairs need at least 2 input cycles, so the output serializer never collides. No backpressure.
- out_valid=0 cycles hold out_data at its last value; out_im=0.
- ovf: set on the cycle the E+2 stage registers an overflowing RE or IM. Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Twiddle (-1, 0) and data -2^(DATA_WIDTH-1) are legal. The resulting overflow goes through the SAT rule.

Test Plan:
Parameters DATA_WIDTH=16, TW_WIDTH=16 unless stated.
- Scale: c=16384, s=0, fwd, a=1000, b=-2000 -> RE=500 at E+3, IM=-1000 at E+4, ovf=0.
- Quarter turn and rounding: c=0, s=32767, a=1000, b=0. ROUND=0 -> RE=0, IM=999. ROUND=1 -> RE=0, IM=1000.
- Saturation: a=b=-32768, c=-32768, s=32767. SAT=1 -> RE=32767, IM=1, ovf=1, ovf stays 1 until ovf_clr. SAT=0 -> RE=-1, IM=1, ovf=1. Same-cycle set with ovf_clr -> ovf=1.
- Inverse: c=s=16384, a=1000, b=0. inverse=0 -> RE=500, IM=500. inverse=1 -> RE=500, IM=-500.
- Gaps/resync: re beat, 5 idle cycles, im beat -> output exactly 3 cycles after im. Send re, then re with in_sop=1 -> sop_err pulse, first re dropped, next im pairs with the second re.
- Reset: assert rst_n=0 with 2 pairs in flight -> all outputs 0 immediately. After release, the first beat is re and no stale outputs appear.

Source files
------------

// File: rtl/twiddle_rotator_pipe.sv
// Pipelined complex twiddle rotator for the serial single-path FFT.
// Interleaved re/im beats in and out, rounding, saturation, sticky overflow.
module twiddle_rotator_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int ROUND      = 1,
  parameter int SAT        = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [TW_WIDTH-1:0]   tw_cos,
  input  logic signed [TW_WIDTH-1:0]   tw_sin,
  input  logic                         inverse,
  input  logic                         ovf_clr,
  output logic                         out_valid,
  output logic                         out_im,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         ovf,
  output logic                         sop_err
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = TW_WIDTH;
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam int RW = DW + 2;

  localparam logic signed [SW-1:0] RND =
    (ROUND != 0) ? (SW'(1) << (TW - 2)) : '0;
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [DW:0] reduce(input logic [RW-1:0] v);
    logic          o;
    logic [DW-1:0] d;
    o = (v[RW-1:DW-1] != {(RW-DW+1){v[RW-1]}});
    d = v[DW-1:0];
    if (o && SAT != 0) d = v[RW-1] ? MINV : MAXV;
    return {o, d};
  endfunction

  logic                 phase;
  logic signed [DW-1:0] re_q;
  logic signed [DW-1:0] b0;
  logic signed [TW-1:0] c0;
  logic signed [TW-1:0] s0;
  logic                 inv0;
  logic                 v0;

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] bx;
  logic signed [PW-1:0] cx;
  logic signed [PW-1:0] sx;

  logic signed [PW-1:0] p_ac;
  logic signed [PW-1:0] p_bs;
  logic signed [PW-1:0] p_bc;
  logic signed [PW-1:0] p_as;
  logic                 inv1;
  logic                 v1;

  logic signed [SW-1:0] re_sum;
  logic signed [SW-1:0] im_sum;
  logic [RW-1:0]        re_sh;
  logic [RW-1:0]        im_sh;
  logic [DW:0]          re_red;
  logic [DW:0]          im_red;

  logic [DW-1:0]        re2;
  logic [DW-1:0]        im2;
  logic                 v2;
  logic                 v3;

  assign ax = PW'(re_q);
  assign bx = PW'(b0);
  assign cx = PW'(c0);
  assign sx = PW'(s0);

  // re_q may be overwritten on the edge that consumes it; NBA keeps it safe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      re_q    <= '0;
      b0      <= '0;
      c0      <= '0;
      s0      <= '0;
      inv0    <= 1'b0;
      v0      <= 1'b0;
      sop_err <= 1'b0;
    end else begin
      v0      <= 1'b0;
      sop_err <= in_valid & in_sop & phase;
      if (in_valid) begin
        if (in_sop || !phase) begin
          re_q  <= in_data;
          phase <= 1'b1;
        end else begin
          b0    <= in_data;
          c0    <= tw_cos;
          s0    <= tw_sin;
          inv0  <= inverse;
          v0    <= 1'b1;
          phase <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ac <= '0;
      p_bs <= '0;
      p_bc <= '0;
      p_as <= '0;
      inv1 <= 1'b0;
      v1   <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        p_ac <= ax * cx;
        p_bs <= bx * sx;
        p_bc <= bx * cx;
        p_as <= ax * sx;
        inv1 <= inv0;
      end
    end
  end

  always_comb begin
    if (inv1) begin
      re_sum = SW'(p_ac) + SW'(p_bs);
      im_sum = SW'(p_bc) - SW'(p_as);
    end else begin
      re_sum = SW'(p_ac) - SW'(p_bs);
      im_sum = SW'(p_bc) + SW'(p_as);
    end
    re_sh  = RW'((re_sum + RND) >>> (TW - 1));
    im_sh  = RW'((im_sum + RND) >>> (TW - 1));
    re_red = reduce(re_sh);
    im_red = reduce(im_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re2 <= '0;
      im2 <= '0;
      v2  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        re2 <= re_red[DW-1:0];
        im2 <= im_red[DW-1:0];
      end
      if (v1 && (re_red[DW] || im_red[DW])) ovf <= 1'b1;
      else if (ovf_clr)                     ovf <= 1'b0;
    end
  end

  // pairs are >=2 cycles apart, so the im slot never meets the next re
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_im    <= 1'b0;
      out_data  <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        out_valid <= 1'b1;
        out_im    <= 1'b0;
        out_data  <= re2;
      end else if (v3) begin
        out_valid <= 1'b1;
        out_im    <= 1'b1;
        out_data  <= im2;
      end else begin
        out_valid <= 1'b0;
        out_im    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_rotator_pipe.sv
// Scoreboard bench for twiddle_rotator_pipe: three rounding/saturation
// variants share one stimulus stream and one expected-result queue.
module tb_twiddle_rotator_pipe;

  localparam bit [2:0] RNDC = 3'b101;
  localparam bit [2:0] SATC = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        inverse = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] tw_cos = '0;
  logic [15:0] tw_sin = '0;

  logic        ov[3];
  logic        oi[3];
  logic        of[3];
  logic        se[3];
  logic [15:0] od[3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0][15:0] re;
    logic [2:0][15:0] im;
    logic [2:0]       ov;
    int               due;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [2:0] exp_ovf = '0;
  bit         exp_im = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twiddle_rotator_pipe #(.ROUND(1), .SAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_data(in_data), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .inverse(inverse), .ovf_clr(ovf_clr), .out_valid(ov[0]),
    .out_im(oi[0]), .out_data(od[0]), .ovf(of[0]), .sop_err(se[0]));

  twiddle_rotator_pipe #(.ROUND(0), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_data(in_data), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .inverse(inverse), .ovf_clr(ovf_clr), .out_valid(ov[1]),
    .out_im(oi[1]), .out_data(od[1]), .ovf(of[1]), .sop_err(se[1]));

  twiddle_rotator_pipe #(.ROUND(1), .SAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_data(in_data), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .inverse(inverse), .ovf_clr(ovf_clr), .out_valid(ov[2]),
    .out_im(oi[2]), .out_data(od[2]), .ovf(of[2]), .sop_err(se[2]));

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input int a, input int b,
      input int c, input int s, input bit inv, input bit rnd,
      input bit sat, input bit im);
    longint      ac;
    longint      bs;
    longint      bc;
    longint      as_;
    longint      v;
    bit          o;
    logic [15:0] r;
    ac  = longint'(a) * c;
    bs  = longint'(b) * s;
    bc  = longint'(b) * c;
    as_ = longint'(a) * s;
    if (im) v = inv ? bc - as_ : bc + as_;
    else    v = inv ? ac + bs : ac - bs;
    if (rnd) v = v + 16384;
    v = v >>> 15;
    o = (v > 32767) || (v < -32768);
    if (o && sat) r = (v < 0) ? 16'h8000 : 16'h7fff;
    else          r = v[15:0];
    return {o, r};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_sop   = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_re(input int a, input bit sop);
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = 16'(a);
    tw_cos   = 16'($urandom);
    tw_sin   = 16'($urandom);
    inverse  = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_im(input int a, input int b, input int c,
                         input int s, input bit inv);
    exp_t        e;
    logic [16:0] r;
    for (int k = 0; k < 3; k++) begin
      r = model(a, b, c, s, inv, RNDC[k], SATC[k], 1'b0);
      e.re[k] = r[15:0];
      e.ov[k] = r[16];
      r = model(a, b, c, s, inv, RNDC[k], SATC[k], 1'b1);
      e.im[k] = r[15:0];
      e.ov[k] = e.ov[k] | r[16];
    end
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_data  = 16'(b);
    tw_cos   = 16'(c);
    tw_sin   = 16'(s);
    inverse  = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.due    = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic pair(input int a, input int b, input int c, input int s,
                      input bit inv, input int gap);
    send_re(a, 1'b0);
    idle(gap);
    send_im(a, b, c, s, inv);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_im = 1'b0;
    end else if (exp_im) begin
      for (int k = 0; k < 3; k++) begin
        chk("im_valid", 32'(ov[k]), 1);
        chk("im_flag", 32'(oi[k]), 1);
        chk("im_data", $signed(od[k]), $signed(cur.im[k]));
      end
      exp_im = 1'b0;
    end else if (ov[0]) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(ov[0]), 0);
      end else begin
        cur = sb.pop_front();
        chk("latency", cyc, cur.due);
        exp_ovf = exp_ovf | cur.ov;
        for (int k = 0; k < 3; k++) begin
          chk("re_valid", 32'(ov[k]), 1);
          chk("re_flag", 32'(oi[k]), 0);
          chk("re_data", $signed(od[k]), $signed(cur.re[k]));
          chk("ovf", 32'(of[k]), 32'(exp_ovf[k]));
        end
        exp_im = 1'b1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("idle_valid", 32'(ov[k]), 0);
        chk("idle_flag", 32'(oi[k]), 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_valid"}, 32'(ov[k]), 0);
      chk({tag, "_im"}, 32'(oi[k]), 0);
      chk({tag, "_data"}, 32'(od[k]), 0);
      chk({tag, "_ovf"}, 32'(of[k]), 0);
      chk({tag, "_soperr"}, 32'(se[k]), 0);
    end
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    exp_ovf = '0;
    for (int k = 0; k < 3; k++) chk("ovf_cleared", 32'(of[k]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, b, c, s;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    pair(1000, -2000, 16384, 0, 1'b0, 0);
    idle(5);
    pair(1000, 0, 0, 32767, 1'b0, 0);
    idle(5);
    pair(1000, 0, 16384, 16384, 1'b0, 0);
    pair(1000, 0, 16384, 16384, 1'b1, 0);
    idle(6);
    pair(-32768, 0, -32768, 0, 1'b0, 1);
    idle(6);
    clear_ovf();

    pair(-32768, -32768, -32768, 32767, 1'b0, 0);
    idle(8);
    for (int k = 0; k < 3; k++) chk("ovf_sticky", 32'(of[k]), 1);
    clear_ovf();

    send_re(-32768, 1'b0);
    send_im(-32768, -32768, -32768, 32767, 1'b0);
    idle(1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    for (int k = 0; k < 3; k++) chk("ovf_set_wins", 32'(of[k]), 1);
    idle(6);
    clear_ovf();

    pair(123, -456, 20000, -15000, 1'b0, 5);
    idle(6);

    send_re(7777, 1'b0);
    send_re(1000, 1'b1);
    for (int k = 0; k < 3; k++) chk("sop_err_pulse", 32'(se[k]), 1);
    send_im(1000, -3000, 16384, 8192, 1'b0);
    for (int k = 0; k < 3; k++) chk("sop_err_end", 32'(se[k]), 0);
    idle(6);
    send_re(500, 1'b1);
    for (int k = 0; k < 3; k++) chk("sop_no_err", 32'(se[k]), 0);
    send_im(500, 700, -20000, 12345, 1'b1);
    idle(6);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      c = int'($urandom_range(0, 65535)) - 32768;
      s = int'($urandom_range(0, 65535)) - 32768;
      pair(a, b, c, s, 1'($urandom), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(6);

    send_re(1111, 1'b0);
    send_im(1111, 2222, 30000, -30000, 1'b0);
    send_re(-3333, 1'b0);
    send_im(-3333, 4444, -30000, 30000, 1'b1);
    send_re(5555, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(posedge clk); #1;
    exp_ovf = '0;
    rst_n   = 1'b1;
    pair(1500, -2500, 16384, 0, 1'b0, 0);
    idle(8);
    chk("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
